// File: rtl/bf_ctrl_gen.sv
// Control generator for the radix-2 SDF FFT pipeline: frame sample counter, per-stage
// butterfly enables, frame-sync tracking and output valid/sof alignment.
module bf_ctrl_gen #(
    parameter int LOG2N     = 7,
    parameter int STAGE_LAT = 1,
    parameter int OUT_DLY   = 134
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [LOG2N-1:0] en_bf,
    output logic             en_valid,
    output logic [LOG2N-1:0] sample_idx,
    output logic             out_valid,
    output logic             out_sof,
    output logic             sof_err
);

    localparam int              FW       = $clog2(OUT_DLY + 1);
    localparam logic [FW-1:0]   FILL_MAX = FW'(OUT_DLY);
    localparam logic [LOG2N-1:0] SOF_IDX = LOG2N'(OUT_DLY % (2 ** LOG2N));

    // Stage k sees the sample that entered (k-1)*STAGE_LAT valid slots earlier;
    // its butterfly is active in the second half of its sub-block.
    function automatic logic [LOG2N-1:0] bf_enables(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] en;
        logic [LOG2N-1:0] rel;
        en = {LOG2N{1'b0}};
        for (int k = 1; k <= LOG2N; k++) begin
            rel       = idx - LOG2N'((k - 1) * STAGE_LAT);
            en[k - 1] = rel[LOG2N - k];
        end
        return en;
    endfunction

    logic [LOG2N-1:0] cnt_r;
    logic [FW-1:0]    fill_r;
    logic [LOG2N-1:0] en_bf_r;
    logic             en_valid_r;
    logic [LOG2N-1:0] sample_idx_r;
    logic             out_valid_r;
    logic             out_sof_r;
    logic             sof_err_r;

    logic             sof_hit_s;
    logic             resync_s;
    logic [LOG2N-1:0] idx_s;
    logic [FW-1:0]    s_s;
    logic             primed_s;
    logic [FW-1:0]    fill_nxt_s;

    // Current sample index, resync detection and saturating fill position
    always_comb begin
        sof_hit_s = in_valid & in_sof;
        resync_s  = sof_hit_s & (cnt_r != {LOG2N{1'b0}});
        if (sof_hit_s) begin
            idx_s = {LOG2N{1'b0}};
        end else begin
            idx_s = cnt_r;
        end
        if (resync_s) begin
            s_s = {FW{1'b0}};
        end else begin
            s_s = fill_r;
        end
        primed_s = (s_s >= FILL_MAX);
        if (primed_s) begin
            fill_nxt_s = FILL_MAX;
        end else begin
            fill_nxt_s = s_s + FW'(1);
        end
    end

    // Counter, fill and registered outputs; an aligned in_sof keeps fill so streaming is gapless
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {LOG2N{1'b0}};
            fill_r       <= {FW{1'b0}};
            en_bf_r      <= {LOG2N{1'b0}};
            en_valid_r   <= 1'b0;
            sample_idx_r <= {LOG2N{1'b0}};
            out_valid_r  <= 1'b0;
            out_sof_r    <= 1'b0;
            sof_err_r    <= 1'b0;
        end else begin
            en_valid_r  <= in_valid;
            out_valid_r <= in_valid & primed_s;
            out_sof_r   <= in_valid & primed_s & (idx_s == SOF_IDX);
            sof_err_r   <= resync_s;
            if (in_valid) begin
                cnt_r        <= idx_s + LOG2N'(1);
                fill_r       <= fill_nxt_s;
                sample_idx_r <= idx_s;
                en_bf_r      <= bf_enables(idx_s);
            end else begin
                cnt_r        <= cnt_r;
                fill_r       <= fill_r;
                sample_idx_r <= sample_idx_r;
                en_bf_r      <= en_bf_r;
            end
        end
    end

    assign en_bf      = en_bf_r;
    assign en_valid   = en_valid_r;
    assign sample_idx = sample_idx_r;
    assign out_valid  = out_valid_r;
    assign out_sof    = out_sof_r;
    assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_bf_ctrl_gen.sv
// Scoreboard bench for bf_ctrl_gen: a behavioural model pushes expected outputs per driven
// cycle; they are popped and compared one clock later. A second instance uses STAGE_LAT=3.
module tb_bf_ctrl_gen;

    localparam int LOG2N   = 7;
    localparam int N       = 128;
    localparam int OUT_DLY = 134;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;

    logic [LOG2N-1:0] en_bf_a, sample_idx_a, en_bf_b, sample_idx_b;
    logic en_valid_a, out_valid_a, out_sof_a, sof_err_a;
    logic en_valid_b, out_valid_b, out_sof_b, sof_err_b;

    always #5 clk = ~clk;

    bf_ctrl_gen #(.LOG2N(LOG2N), .STAGE_LAT(1), .OUT_DLY(OUT_DLY)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .en_bf(en_bf_a), .en_valid(en_valid_a), .sample_idx(sample_idx_a),
        .out_valid(out_valid_a), .out_sof(out_sof_a), .sof_err(sof_err_a)
    );

    bf_ctrl_gen #(.LOG2N(LOG2N), .STAGE_LAT(3), .OUT_DLY(OUT_DLY)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .en_bf(en_bf_b), .en_valid(en_valid_b), .sample_idx(sample_idx_b),
        .out_valid(out_valid_b), .out_sof(out_sof_b), .sof_err(sof_err_b)
    );

    typedef struct packed {
        logic [6:0] bf_a;
        logic [6:0] bf_b;
        logic       en_valid;
        logic [6:0] sidx;
        logic       out_valid;
        logic       out_sof;
        logic       sof_err;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int sof_err_seen = 0;

    int       m_cnt = 0;
    int       m_fill = 0;
    int       m_idx = 0;
    logic [6:0] m_bfa = 7'd0;
    logic [6:0] m_bfb = 7'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] bf_model(input int idx, input int lat);
        logic [6:0] b;
        int rel;
        b = 7'd0;
        for (int k = 1; k <= LOG2N; k++) begin
            rel = ((idx - (k - 1) * lat) % N + N) % N;
            b[k - 1] = ((rel >> (LOG2N - k)) & 1) != 0;
        end
        return b;
    endfunction

    // Drive one cycle, push the model's expectation, then pop and compare after the edge
    task automatic step(input logic v, input logic sof, input logic r);
        exp_t e;
        int idx;
        int s;
        bit resync;
        in_valid = v;
        in_sof   = sof;
        rst      = r;
        e = '0;
        if (r) begin
            m_cnt = 0; m_fill = 0; m_idx = 0; m_bfa = 7'd0; m_bfb = 7'd0;
        end else begin
            resync = v && sof && (m_cnt != 0);
            idx    = (v && sof) ? 0 : m_cnt;
            s      = resync ? 0 : m_fill;
            if (v) begin
                m_cnt  = (idx + 1) % N;
                m_fill = (s + 1 > OUT_DLY) ? OUT_DLY : s + 1;
                m_idx  = idx;
                m_bfa  = bf_model(idx, 1);
                m_bfb  = bf_model(idx, 3);
            end
            e.bf_a      = m_bfa;
            e.bf_b      = m_bfb;
            e.en_valid  = v;
            e.sidx      = 7'(m_idx);
            e.out_valid = v && (s >= OUT_DLY);
            e.out_sof   = v && (s >= OUT_DLY) && (idx == OUT_DLY % N);
            e.sof_err   = resync;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("en_bf",      32'(en_bf_a),      32'(e.bf_a));
        check_val("en_bf_lat3", 32'(en_bf_b),      32'(e.bf_b));
        check_val("en_valid",   32'(en_valid_a),   32'(e.en_valid));
        check_val("sample_idx", 32'(sample_idx_a), 32'(e.sidx));
        check_val("out_valid",  32'(out_valid_a),  32'(e.out_valid));
        check_val("out_sof",    32'(out_sof_a),    32'(e.out_sof));
        check_val("sof_err",    32'(sof_err_a),    32'(e.sof_err));
        if (sof_err_a) sof_err_seen++;
        in_sof = 1'b0;
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("rst_all", {en_bf_a, sample_idx_a, en_valid_a, out_valid_a, out_sof_a, sof_err_a}, 32'd0);

        // 1/5: one frame back to back, with fixed reference points
        for (int i = 0; i < N; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 6)  check_val("t1_bf6_idx6", 32'(en_bf_a[6]), 32'd0);
            if (i == 7)  check_val("t1_bf6_idx7", 32'(en_bf_a[6]), 32'd1);
            if (i == 63) check_val("t1_bf0_idx63", 32'(en_bf_a[0]), 32'd0);
            if (i == 64) check_val("t1_bf0_idx64", 32'(en_bf_a[0]), 32'd1);
            if (i == 0)  check_val("t5_bf1_idx0", 32'(en_bf_b[1]), 32'd1);
            if (i == 18) check_val("t5_bf6_idx18", 32'(en_bf_b[6]), 32'd0);
            if (i == 19) check_val("t5_bf6_idx19", 32'(en_bf_b[6]), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0);
        check_val("t1_en_valid_drop", 32'(en_valid_a), 32'd0);

        // 2: random gaps
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 250; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // 3: long stream from reset
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 133) check_val("t3_ov_133", 32'(out_valid_a), 32'd0);
            if (i == 134) check_val("t3_ov_sof_134", {out_valid_a, out_sof_a, sample_idx_a}, {2'b11, 7'd6});
            if (i == 262) check_val("t3_sof_262", {out_valid_a, out_sof_a, sample_idx_a}, {2'b11, 7'd6});
        end

        // 4: misaligned resync at sample 200, then aligned sof at sample 456 (idx 0)
        step(1'b0, 1'b0, 1'b1);
        sof_err_seen = 0;
        for (int i = 0; i < 470; i++) begin
            step(1'b1, (i == 200 || i == 456) ? 1'b1 : 1'b0, 1'b0);
            if (i == 200) check_val("t4_resync", {sof_err_a, sample_idx_a}, {1'b1, 7'd0});
            if (i == 201) check_val("t4_ov_drop", 32'(out_valid_a), 32'd0);
            if (i == 333) check_val("t4_ov_333", 32'(out_valid_a), 32'd0);
            if (i == 334) check_val("t4_ov_sof_334", {out_valid_a, out_sof_a}, 2'b11);
            if (i == 456) check_val("t4_aligned", {sof_err_a, out_valid_a, sample_idx_a}, {2'b01, 7'd0});
        end
        check_val("t4_err_pulses", 32'(sof_err_seen), 32'd1);

        // 6: reset mid-frame together with valid+sof
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 90; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_val("t6_rst_outs", {en_bf_a, sample_idx_a, en_valid_a, out_valid_a, out_sof_a, sof_err_a}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check_val("t6_first_idx", {sof_err_a, en_valid_a, sample_idx_a}, {2'b01, 7'd0});
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
